// File: rtl/demux_32_bit_buffered.sv
// demux_32_bit_buffered: steers a 32-bit word stream into one of two
// independent FIFO channels. Each channel keeps its own count of accepted words.

// One output channel: circular buffer with occupancy tracking and an
// accepted-word counter.
module demux_32_bit_buffered_chan #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [31:0]      wdata,
  input  logic             pop_req,
  output logic             full,
  output logic             head_valid,
  output logic [31:0]      head,
  output logic [CNT_W-1:0] cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [OW-1:0] occ;
  logic          wr;
  logic          rd;

  // Push is dropped when full; pop only acts on a valid head.
  assign full       = (occ == OW'(DEPTH));
  assign head_valid = (occ != '0);
  assign wr         = push & ~full;
  assign rd         = pop_req & head_valid;

  // Head word is forced to zero while the channel is empty.
  assign head = head_valid ? mem[rptr] : 32'h0;

  // Pointers, occupancy and accepted-word counter; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      cnt  <= '0;
    end else begin
      if (wr) begin
        wptr <= wptr + AW'(1);
        cnt  <= cnt + CNT_W'(1);
      end
      if (rd) begin
        rptr <= rptr + AW'(1);
      end
      case ({wr, rd})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage array; contents are don't-care until occupancy covers them.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr] <= wdata;
    end
  end

endmodule

// Top level: select-driven steering into two buffered channels.
module demux_32_bit_buffered #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             select,
  output logic             in_ready,
  output logic [31:0]      out_0,
  output logic             out_0_valid,
  input  logic             out_0_ready,
  output logic [31:0]      out_1,
  output logic             out_1_valid,
  input  logic             out_1_ready,
  output logic [CNT_W-1:0] cnt_0,
  output logic [CNT_W-1:0] cnt_1
);

  logic full_0;
  logic full_1;
  logic push_0;
  logic push_1;

  // Ready depends only on select and the targeted channel's occupancy.
  assign in_ready = select ? ~full_1 : ~full_0;
  assign push_0   = in_valid & in_ready & ~select;
  assign push_1   = in_valid & in_ready & select;

  demux_32_bit_buffered_chan #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chan_0 (
    .clk        (clk),
    .rst        (rst),
    .push       (push_0),
    .wdata      (in_data),
    .pop_req    (out_0_ready),
    .full       (full_0),
    .head_valid (out_0_valid),
    .head       (out_0),
    .cnt        (cnt_0)
  );

  demux_32_bit_buffered_chan #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chan_1 (
    .clk        (clk),
    .rst        (rst),
    .push       (push_1),
    .wdata      (in_data),
    .pop_req    (out_1_ready),
    .full       (full_1),
    .head_valid (out_1_valid),
    .head       (out_1),
    .cnt        (cnt_1)
  );

endmodule

// File: tb/tb_demux_32_bit_buffered.sv
// Testbench for demux_32_bit_buffered: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_demux_32_bit_buffered;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [31:0]      in_data;
  logic             in_valid;
  logic             select;
  logic             in_ready;
  logic [31:0]      out_0;
  logic             out_0_valid;
  logic             out_0_ready;
  logic [31:0]      out_1;
  logic             out_1_valid;
  logic             out_1_ready;
  logic [CNT_W-1:0] cnt_0;
  logic [CNT_W-1:0] cnt_1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: one queue and one wrapping counter per channel.
  logic [31:0]      q0[$];
  logic [31:0]      q1[$];
  logic [CNT_W-1:0] mc0;
  logic [CNT_W-1:0] mc1;

  demux_32_bit_buffered #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .select      (select),
    .in_ready    (in_ready),
    .out_0       (out_0),
    .out_0_valid (out_0_valid),
    .out_0_ready (out_0_ready),
    .out_1       (out_1),
    .out_1_valid (out_1_valid),
    .out_1_ready (out_1_ready),
    .cnt_0       (cnt_0),
    .cnt_1       (cnt_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: pops and pushes decided from pre-edge occupancy.
  always @(posedge clk or posedge rst) begin
    bit pop0, pop1, acc;
    if (rst) begin
      q0.delete();
      q1.delete();
      mc0 = '0;
      mc1 = '0;
    end else begin
      pop0 = out_0_ready && (q0.size() > 0);
      pop1 = out_1_ready && (q1.size() > 0);
      acc  = in_valid && (select ? (q1.size() < DEPTH) : (q0.size() < DEPTH));
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (acc) begin
        if (select) begin
          q1.push_back(in_data);
          mc1 = mc1 + 1'b1;
        end else begin
          q0.push_back(in_data);
          mc0 = mc0 + 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    logic exp_rdy;
    exp_rdy = select ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    chk("in_ready",    32'(in_ready),    32'(exp_rdy));
    chk("out_0_valid", 32'(out_0_valid), 32'(q0.size() > 0));
    chk("out_1_valid", 32'(out_1_valid), 32'(q1.size() > 0));
    chk("out_0",       out_0, (q0.size() > 0) ? q0[0] : 32'h0);
    chk("out_1",       out_1, (q1.size() > 0) ? q1[0] : 32'h0);
    chk("cnt_0",       32'(cnt_0), 32'(mc0));
    chk("cnt_1",       32'(cnt_1), 32'(mc1));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Asynchronous reset pulse between edges; outputs must clear with no edge.
  task automatic pulse_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst out_0_valid", 32'(out_0_valid), 32'h0);
    chk("rst out_1_valid", 32'(out_1_valid), 32'h0);
    chk("rst out_0",       out_0, 32'h0);
    chk("rst out_1",       out_1, 32'h0);
    chk("rst cnt_0",       32'(cnt_0), 32'h0);
    chk("rst cnt_1",       32'(cnt_1), 32'h0);
    chk("rst in_ready",    32'(in_ready), 32'h1);
    in_valid    = 1'b0;
    out_0_ready = 1'b0;
    out_1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [31:0] last;
    rst         = 1'b1;
    in_data     = '0;
    in_valid    = 1'b0;
    select      = 1'b0;
    out_0_ready = 1'b0;
    out_1_ready = 1'b0;
    #1;
    chk("init out_0_valid", 32'(out_0_valid), 32'h0);
    chk("init in_ready",    32'(in_ready), 32'h1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Steering: one word into each channel, consumers stalled.
    in_valid = 1'b1; select = 1'b0; in_data = 32'hAAAAAAAA;
    cyc();
    select = 1'b1; in_data = 32'h55555555;
    cyc();
    in_valid = 1'b0;
    #1;
    chk("steer out_0",  out_0, 32'hAAAAAAAA);
    chk("steer out_1",  out_1, 32'h55555555);
    chk("steer v0",     32'(out_0_valid), 32'h1);
    chk("steer v1",     32'(out_1_valid), 32'h1);
    chk("steer cnt_0",  32'(cnt_0), 32'h1);
    chk("steer cnt_1",  32'(cnt_1), 32'h1);

    // Reset with both channels partly full.
    pulse_reset();

    // Full / backpressure on channel 0.
    select = 1'b0; in_valid = 1'b1; in_data = 32'h1;
    cyc();
    in_data = 32'h2;
    #1 chk("full rdy after 1", 32'(in_ready), 32'h1);
    cyc();
    in_data = 32'h3;
    #1 chk("full rdy after 2", 32'(in_ready), 32'h0);
    cyc();
    #1;
    chk("full rdy held",  32'(in_ready), 32'h0);
    chk("full cnt_0",     32'(cnt_0), 32'h2);
    chk("full out_0",     out_0, 32'h1);
    select = 1'b1;
    #1 chk("full rdy sel1", 32'(in_ready), 32'h1);
    in_valid = 1'b0;
    pulse_reset();

    // Ordering with simultaneous push and pop at occupancy 1.
    select = 1'b0; in_valid = 1'b1; in_data = 32'h10;
    cyc();
    #1 chk("order head 10", out_0, 32'h10);
    for (int i = 0; i < 7; i++) begin
      in_data = 32'h11 + 32'(i);
      out_0_ready = 1'b1;
      cyc();
      #1;
      chk("order head", out_0, 32'h11 + 32'(i));
      chk("order valid", 32'(out_0_valid), 32'h1);
    end
    in_valid = 1'b0; out_0_ready = 1'b0;
    #1;
    chk("order last", out_0, 32'h17);
    chk("order cnt_0", 32'(cnt_0), 32'h8);
    pulse_reset();

    // Counter and pointer wrap: 258 words through channel 0.
    out_0_ready = 1'b1; select = 1'b0; in_valid = 1'b1;
    last = '0;
    for (int i = 0; i < 258; i++) begin
      in_data = $urandom;
      last = in_data;
      cyc();
    end
    in_valid = 1'b0;
    out_0_ready = 1'b0;
    #1;
    chk("wrap cnt_0", 32'(cnt_0), 32'h2);
    chk("wrap out_0", out_0, last);
    pulse_reset();

    // Cross-channel: pop channel 1 while pushing channel 0.
    select = 1'b1; in_valid = 1'b1; in_data = 32'hA1;
    cyc();
    in_data = 32'hA2;
    cyc();
    select = 1'b0; in_data = 32'hB0; out_1_ready = 1'b1;
    cyc();
    in_valid = 1'b0; out_1_ready = 1'b0;
    #1;
    chk("cross cnt_0", 32'(cnt_0), 32'h1);
    chk("cross cnt_1", 32'(cnt_1), 32'h2);
    chk("cross out_0", out_0, 32'hB0);
    chk("cross out_1", out_1, 32'hA2);

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        pulse_reset();
      end
      in_valid    = ($urandom_range(0, 3) != 0);
      select      = 1'($urandom_range(0, 1));
      in_data     = $urandom;
      out_0_ready = ($urandom_range(0, 2) != 0);
      out_1_ready = ($urandom_range(0, 2) == 0);
      cyc();
    end

    in_valid = 1'b0; out_0_ready = 1'b1; out_1_ready = 1'b1;
    repeat (4) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux_32_bit_buffered.md
DEMUX_32_BIT_BUFFERED -- requirements
Module: demux_32_bit_buffered

Interface
REQ-001 Parameter DEPTH, default 2, entries per output channel FIFO; power of two, minimum 2.
REQ-002 Parameter CNT_W, default 8, width of the per-channel accepted-word counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_data  input  32  word to be steered.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 select  input  1  destination channel, sampled with in_data (0 = channel 0, 1 = channel 1).
REQ-008 in_ready  output  1  the selected channel can accept a word this cycle.
REQ-009 out_0 / out_1  output  32 each  head word of the channel 0 / channel 1 FIFO.
REQ-010 out_0_valid / out_1_valid  output  1 each  the corresponding head word is valid.
REQ-011 out_0_ready / out_1_ready  input  1 each  the downstream consumer takes the head word.
REQ-012 cnt_0 / cnt_1  output  CNT_W each  number of words accepted into channel 0 / channel 1.

Function
REQ-013 Push: a word SHALL be accepted on a rising edge when in_valid and in_ready are both 1 at that edge; it is written into the FIFO chosen by select.
REQ-014 in_ready SHALL be 1 exactly when the FIFO chosen by the current select is not full.
  - Combinational from select and the occupancy registers only; no path from out_x_ready.
REQ-015 Pop: the channel x head SHALL be removed on a rising edge when out_x_valid and out_x_ready are both 1 at that edge.
REQ-016 out_x_valid SHALL be 1 exactly when channel x occupancy > 0.
  - out_x SHALL present the head word when valid and 32'h0 when empty.
REQ-017 Latency: a word accepted at edge k into an empty channel SHALL appear on out_x with out_x_valid=1 immediately after edge k (1 cycle); no bypass within the same cycle.
REQ-018 Each channel SHALL deliver words in acceptance order; the channels are independent, with no ordering relation between them.
REQ-019 Occupancy per channel SHALL be 0..DEPTH and tracked with read/write pointers that wrap modulo DEPTH.
REQ-020 Simultaneous push and pop on the same channel with occupancy >= 1: occupancy unchanged, both pointers advance, head updates correctly.
REQ-021 Push and pop on the same channel at occupancy 0 SHALL NOT occur, because out_x_valid=0.
  - Push at occupancy DEPTH is blocked by in_ready=0.
REQ-022 A pop on one channel and a push on the other in the same cycle SHALL both take effect.
REQ-023 out_x_ready asserted while out_x_valid=0 SHALL have no effect.
  - in_data and select are ignored when in_valid=0.
REQ-024 cnt_x SHALL increment by 1 on every push into channel x and wrap from 2^CNT_W-1 to 0 with no flag.
REQ-025 A word offered while in_ready=0 is not accepted; the producer holds it, and the block SHALL NOT store or count it.
REQ-026 Changing select while in_valid=1 and in_ready=0 is permitted; in_ready re-evaluates for the new channel in the same cycle.

Reset
REQ-027 While rst=1, regardless of clk:
  - all occupancies, pointers and counters SHALL be 0;
  - out_0 = out_1 = 32'h0, out_0_valid = out_1_valid = 0.
REQ-028 During and after reset, in_ready SHALL be 1, since both channels are empty.
REQ-029 Assertion of rst mid-operation SHALL discard all buffered words immediately.
  - No word accepted before reset SHALL appear on an output after reset.
REQ-030 The first push after rst deasserts SHALL be honoured at the first rising edge where rst=0.

Verification
REQ-031 Reset check: assert rst with FIFOs partly full -> out_0_valid=out_1_valid=0, out_0=out_1=32'h0, cnt_0=cnt_1=0, in_ready=1, all without a clock edge.
REQ-032 Steering check: push 32'hAAAAAAAA with select=0, then 32'h55555555 with select=1, both readies 0 -> out_0=32'hAAAAAAAA, out_1=32'h55555555, both valid, cnt_0=cnt_1=1.
REQ-033 Full/backpressure (DEPTH=2, out_0_ready=0): push 32'h1, 32'h2, 32'h3 to channel 0 -> in_ready drops after the second push; 32'h3 is not accepted; cnt_0=2; switching select to 1 raises in_ready to 1 in the same cycle.
REQ-034 Ordering and simultaneous events: hold out_0_ready=1 with channel 0 at occupancy 1 and stream 32'h10..32'h17 into it -> out_0 shows 32'h10..32'h17 in order, one per cycle, and occupancy stays 1.
REQ-035 Wrap-around: with out_0_ready=1, push 258 words into channel 0 (CNT_W=8) -> cnt_0=2; FIFO pointers wrap with no data loss.
REQ-036 Cross-channel: in the same cycle, pop channel 1 and push channel 0 -> both take effect; cnt_0 increments; cnt_1 unchanged; channel 1 occupancy decrements.
